icache: RTL

- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and the memory controller.
- Serves hits in one cycle.
- On a miss, issues one 4-byte read on the controller's icache channel, fills the line, then returns the instruction.
- Exactly one miss outstanding at any time; no write path (instruction memory is read-only here).

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_if.sv | 27 ++
 rtl/icache_array.sv | 44 ++++
 rtl/icache.sv | 115 +++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped, one-word-per-line instruction cache.
package icache_pkg;

    localparam int unsigned INDEX_BITS = 6;
    localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Results are zero-extended to 32 bits; callers cast to their own field width.
    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int unsigned ib = INDEX_BITS);
        return (pc >> 2) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned ib = INDEX_BITS);
        return pc >> (ib + 2);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-unit and memory-controller signals of the instruction cache.
interface icache_if;

    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_received;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  fetch_valid, fetch_pc, flush, mem_received, mem_done, mem_data,
        output fetch_ready, inst_valid, inst_out, inst_pc, mem_req, mem_addr
    );

    modport master (
        output fetch_valid, fetch_pc, flush, mem_received, mem_done, mem_data,
        input  fetch_ready, inst_valid, inst_out, inst_pc, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one synchronous write, async valid clear.
module icache_array #(
    parameter int unsigned INDEX_BITS = icache_pkg::INDEX_BITS,
    parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] widx_i,
    input  logic [TAG_BITS-1:0]   wtag_i,
    input  logic [31:0]           wdata_i,
    input  logic [INDEX_BITS-1:0] ridx_i,
    output logic                  rvalid_o,
    output logic [TAG_BITS-1:0]   rtag_o,
    output logic [31:0]           rdata_o
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag and data are left unreset; a cleared valid bit masks them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Instruction cache top: hit path and single-outstanding-miss refill FSM.
module icache #(
    parameter int unsigned INDEX_BITS = icache_pkg::INDEX_BITS,
    parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    icache_if.slave bus
);

    import icache_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic [INDEX_BITS-1:0] ridx, widx;
    logic [TAG_BITS-1:0]   rd_tag, wtag;
    logic [31:0]           rd_data;
    logic                  rd_valid, hit, we;

    assign ridx = INDEX_BITS'(idx_of(bus.fetch_pc, INDEX_BITS));
    assign widx = INDEX_BITS'(idx_of(pc_q, INDEX_BITS));
    assign wtag = TAG_BITS'(tag_of(pc_q, INDEX_BITS));
    assign hit  = rd_valid && (rd_tag == TAG_BITS'(tag_of(bus.fetch_pc, INDEX_BITS)));

    icache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .we_i    (we && rdy_in),
        .widx_i  (widx),
        .wtag_i  (wtag),
        .wdata_i (bus.mem_data),
        .ridx_i  (ridx),
        .rvalid_o(rd_valid),
        .rtag_o  (rd_tag),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        inst_valid_d = 1'b0;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        we           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fetch_valid && !bus.flush) begin
                    if (hit) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = rd_data;
                        inst_pc_d    = bus.fetch_pc;
                    end else begin
                        pc_d    = bus.fetch_pc;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.flush) discard_d = 1'b1;
                if (bus.mem_received) state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush) discard_d = 1'b1;
                // A flush coinciding with mem_done still fills the line but suppresses delivery.
                if (bus.mem_done) begin
                    we = 1'b1;
                    if (!discard_q && !bus.flush) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = bus.mem_data;
                        inst_pc_d    = pc_q;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign bus.fetch_ready = (state_q == IDLE);
    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = {pc_q[31:2], 2'b00};
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.inst_pc     = inst_pc_q;

endmodule
